// File: rtl/cbus_arbiter.sv
// CBus arbiter: shares one memory-side CBus port among NUM_REQ requesters
// (0 = ICache, 1 = DCache, 2 = uncached). Round-robin grant, locked for a
// whole burst, with beat counting and a sticky protocol-violation flag.

package cbus_pkg;
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN16 = 4'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  len;     // beats - 1
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  cbus_req_t           ireqs  [NUM_REQ],
  output cbus_resp_t          oresps [NUM_REQ],
  output cbus_req_t           oreq,
  input  cbus_resp_t          iresp,
  output logic                busy,
  output logic [IDX_BITS-1:0] owner,
  output logic                proto_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] owner_q, owner_d;
  logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                proto_err_q, proto_err_d;
  logic [31:0]         addr_q, addr_d;
  logic                is_write_q, is_write_d;
  logic [3:0]          len_q, len_d;

  logic                grant_found;
  logic [IDX_BITS-1:0] grant_idx;
  logic [IDX_BITS-1:0] scan_idx;
  cbus_req_t           owner_req;
  logic [8:0]          beat_inc;
  logic [8:0]          exp_beats;

  // Wrap with an explicit compare so non-power-of-2 NUM_REQ stays correct.
  function automatic logic [IDX_BITS-1:0] next_idx(input logic [IDX_BITS-1:0] i);
    return (i == IDX_BITS'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign owner_req = ireqs[owner_q];
  assign beat_inc  = {1'b0, beat_cnt_q} + 9'd1;
  assign exp_beats = {5'd0, len_q} + 9'd1;

  // Round-robin scan: first valid requester at or after rr_ptr wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    scan_idx    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && ireqs[scan_idx].valid) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  // Next-state logic: grant, beat counting, completion and violation detection.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q;
    addr_d      = addr_q;
    is_write_d  = is_write_q;
    len_d       = len_q;
    unique case (state_q)
      IDLE: begin
        if (iresp.ready) proto_err_d = 1'b1;  // memory must not respond unasked
        if (grant_found) begin
          state_d    = BUSY;
          owner_d    = grant_idx;
          beat_cnt_d = '0;
          addr_d     = ireqs[grant_idx].addr;
          is_write_d = ireqs[grant_idx].is_write;
          len_d      = ireqs[grant_idx].len;
        end
      end
      BUSY: begin
        // The owner must hold valid and a stable command until the last beat.
        if (!owner_req.valid) proto_err_d = 1'b1;
        if (owner_req.addr != addr_q || owner_req.is_write != is_write_q ||
            owner_req.len != len_q) proto_err_d = 1'b1;
        if (iresp.ready) begin
          if (beat_cnt_q != 8'hff) beat_cnt_d = beat_cnt_q + 8'd1;
          if (iresp.last) begin
            if (beat_inc != exp_beats) proto_err_d = 1'b1;
            // Completion always returns to IDLE, giving one gap cycle.
            state_d    = IDLE;
            rr_ptr_d   = next_idx(owner_q);
            beat_cnt_d = '0;
          end else if (beat_inc == exp_beats) begin
            proto_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight burst immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
      addr_q      <= '0;
      is_write_q  <= 1'b0;
      len_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
      addr_q      <= addr_d;
      is_write_q  <= is_write_d;
      len_q       <= len_d;
    end
  end

  // Output routing: the owner is connected straight through while BUSY.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) oresps[i] = '0;
    if (state_q == BUSY) begin
      oreq            = owner_req;
      oresps[owner_q] = iresp;
    end
  end

  assign busy      = (state_q == BUSY);
  assign owner     = owner_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Randomized bench for cbus_arbiter against a transaction-level model.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  cbus_req_t  ireqs  [N];
  cbus_resp_t oresps [N];
  cbus_req_t  oreq;
  cbus_resp_t iresp;
  logic       busy;
  logic [1:0] owner;
  logic       proto_err;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .oresps(oresps), .oreq(oreq),
    .iresp(iresp), .busy(busy), .owner(owner), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side traffic state.
  bit          pend[N];
  bit          just_done[N];
  bit          r_drop[N];
  logic [31:0] r_addr[N];
  bit          r_wr[N];
  logic [3:0]  r_len[N];
  bit          err_mode;

  // Reference model: who holds the bus, how many beats seen, what was granted.
  bit          m_busy;
  int          m_owner, m_rr, m_beats, m_len;
  bit          m_err, m_wr;
  logic [31:0] m_addr;

  function automatic int pick(input int rr);
    for (int k = 0; k < N; k++)
      if (ireqs[(rr + k) % N].valid) return (rr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_err = 0;
    for (int i = 0; i < N; i++) r_drop[i] = 0;
  endtask

  task automatic model_edge();
    int w, nb;
    if (!m_busy) begin
      if (iresp.ready) m_err = 1;
      w = pick(m_rr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_beats = 0;
        m_addr = ireqs[w].addr; m_wr = ireqs[w].is_write; m_len = int'(ireqs[w].len);
      end
    end else begin
      if (!ireqs[m_owner].valid) m_err = 1;
      if (ireqs[m_owner].addr != m_addr || ireqs[m_owner].is_write != m_wr ||
          int'(ireqs[m_owner].len) != m_len) m_err = 1;
      if (iresp.ready) begin
        nb = m_beats + 1;
        if (iresp.last) begin
          if (nb != m_len + 1) m_err = 1;
          pend[m_owner] = 0; r_drop[m_owner] = 0; just_done[m_owner] = 1;
          m_rr = (m_owner + 1) % N;
          m_busy = 0; m_beats = 0;
        end else begin
          if (nb == m_len + 1) m_err = 1;
          m_beats = (nb > 255) ? 255 : nb;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    cbus_req_t  exp_req;
    cbus_resp_t exp_rsp;
    check("busy", 128'(busy), 128'(m_busy));
    check("owner", 128'(owner), 128'(m_owner));
    check("proto_err", 128'(proto_err), 128'(m_err));
    exp_req = m_busy ? ireqs[m_owner] : '0;
    check("oreq", 128'(oreq), 128'(exp_req));
    for (int i = 0; i < N; i++) begin
      exp_rsp = (m_busy && m_owner == i) ? iresp : '0;
      check($sformatf("oresps%0d", i), 128'(oresps[i]), 128'(exp_rsp));
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, compare, then advance.
  task automatic step(input bit rst_pulse);
    int nb;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && !just_done[i] && $urandom_range(99) < 30) begin
        pend[i] = 1; r_drop[i] = 0;
        r_addr[i] = $urandom & 32'hffff_fffc;
        r_wr[i] = 1'($urandom_range(1));
        case ($urandom_range(2))
          0:       r_len[i] = MLEN1;
          1:       r_len[i] = MLEN16;
          default: r_len[i] = 4'($urandom_range(15));
        endcase
      end
      just_done[i] = 0;
      if (err_mode && pend[i] && m_busy && m_owner == i) begin
        if ($urandom_range(99) < 3) r_drop[i] = 1;
        if ($urandom_range(99) < 3) r_addr[i] = r_addr[i] ^ 32'h10;
      end
      ireqs[i].valid    = pend[i] && !r_drop[i];
      ireqs[i].is_write = r_wr[i];
      ireqs[i].addr     = r_addr[i];
      ireqs[i].len      = r_len[i];
      ireqs[i].wdata    = $urandom;
    end
    iresp.data = $urandom;
    if (m_busy) begin
      nb = m_beats + 1;
      iresp.ready = ($urandom_range(99) < 60);
      iresp.last  = iresp.ready && (nb >= m_len + 1);
      if (err_mode && nb < m_len + 4 && $urandom_range(99) < 8)
        iresp.last = iresp.ready && !(nb >= m_len + 1);
    end else begin
      iresp.ready = err_mode && ($urandom_range(99) < 5);
      iresp.last  = 1'b0;
    end
    #1;
    compare_outputs();
    if (rst_pulse) begin
      #2 reset = 1'b0;
      #1;
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_owner", 128'(owner), 128'(0));
      check("rst_oreq", 128'(oreq), 128'(0));
      check("rst_err", 128'(proto_err), 128'(0));
      model_reset();
      @(negedge clk);
      reset = 1'b1;
    end else begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ireqs[i] = '0; pend[i] = 0; just_done[i] = 0; r_drop[i] = 0;
      r_addr[i] = '0; r_wr[i] = 0; r_len[i] = '0;
    end
    iresp = '0;
    err_mode = 0;
    model_reset();
    #12;
    check("init_busy", 128'(busy), 128'(0));
    check("init_owner", 128'(owner), 128'(0));
    check("init_err", 128'(proto_err), 128'(0));
    check("init_oreq", 128'(oreq), 128'(0));
    for (int i = 0; i < N; i++)
      check($sformatf("init_oresps%0d", i), 128'(oresps[i]), 128'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int ep = 0; ep < 8; ep++) begin
      err_mode = ep[0];
      for (int c = 0; c < 300; c++)
        step(c == 150 && m_busy);
      // Clean restart between episodes so the sticky flag is re-armed.
      step(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
